// File: rtl/lmg_move_sequencer.sv
// lmg_move_sequencer: runs one legal-move-generation pass and writes the result list to RAM.
// Latency: 1 POP + 1 LATCH + SCAN cycles per FIFO word, plus HDR and TERM.
//          SCAN costs 8 cycles per word, or max(k,1) with LMG_SEQ_SKIP_INVALID_EN.
// Backpressure: none on the RAM side; FIFO pops only when lmg_fifo_empty is low.
//
// Optional build macro: LMG_SEQ_SKIP_INVALID_EN. When defined, SCAN visits only
// the valid slots of each word via a priority encoder. RAM contents, move_count
// and overflow are the same in both builds; only the cycle counts differ.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   start, board_in   level start (rising edge launches a pass), board to load
//   busy, done        pass in progress / pass finished (held until start drops)
//   move_count        moves written, valid with done
//   overflow          more than MAX_MOVES valid moves were offered, valid with done
//   lmg_reset         one-cycle LMG reset pulse
//   lmg_bstate        registered board copy driven to the LMG
//   lmg_done          LMG finished generating
//   lmg_rden          one-cycle FIFO pop; data valid on lmg_fifo_out one cycle later
//   lmg_fifo_out      FIFO word, SLOTS slots of SLOT_WIDTH bits (MSB = invalid)
//   lmg_fifo_empty    FIFO empty
//   ram_wraddr/ram_data/ram_wren  result RAM write port

module lmg_move_sequencer #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int SLOT_WIDTH = 19,
    parameter int SLOTS      = 8,
    parameter int BASE_ADDR  = 16,
    parameter int MAX_MOVES  = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [255:0]                  board_in,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    move_count,
    output logic                          overflow,
    output logic                          lmg_reset,
    output logic [255:0]                  lmg_bstate,
    input  logic                          lmg_done,
    output logic                          lmg_rden,
    input  logic [SLOTS*SLOT_WIDTH-1:0]   lmg_fifo_out,
    input  logic                          lmg_fifo_empty,
    output logic [ADDR_WIDTH-1:0]         ram_wraddr,
    output logic [DATA_WIDTH-1:0]         ram_data,
    output logic                          ram_wren
);

    localparam int MOVE_W = SLOT_WIDTH - 1;
    localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int WORD_W = SLOTS * SLOT_WIDTH;

    localparam logic [7:0]            MAX_C    = 8'(MAX_MOVES);
    localparam logic [ADDR_WIDTH-1:0] HDR_A    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LIST_A   = ADDR_WIDTH'(BASE_ADDR + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DONE,
        S_POP,
        S_LATCH,
        S_SCAN,
        S_HDR,
        S_TERM,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic                    start_prev_q;
    logic [WORD_W-1:0]       word_q;
    logic [7:0]              count_q;
    logic                    ovf_q;

    // Registered outputs
    logic                    busy_q;
    logic                    done_q;
    logic [7:0]              move_count_q;
    logic                    overflow_q;
    logic                    lmg_reset_q;
    logic [255:0]            lmg_bstate_q;
    logic                    lmg_rden_q;
    logic [ADDR_WIDTH-1:0]   ram_wraddr_q;
    logic [DATA_WIDTH-1:0]   ram_data_q;
    logic                    ram_wren_q;

    // Slot unpacking of the latched word and of the live FIFO output
    logic [SLOTS-1:0]        word_inv;
    logic [SLOTS-1:0]        fifo_inv;
    logic [MOVE_W-1:0]       word_mv [SLOTS];

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        assign word_inv[g] = word_q[g*SLOT_WIDTH + MOVE_W];
        assign fifo_inv[g] = lmg_fifo_out[g*SLOT_WIDTH + MOVE_W];
        assign word_mv[g]  = word_q[g*SLOT_WIDTH +: MOVE_W];
    end

    // Per-cycle SCAN selection: which slot, whether it holds a move, and
    // whether this is the last SCAN cycle for the current word.
    logic [IDX_W-1:0]        scan_idx;
    logic                    scan_hit;
    logic                    scan_last;
    logic [MOVE_W-1:0]       scan_move;

`ifdef LMG_SEQ_SKIP_INVALID_EN
    // Mask of valid slots not yet written for the current word.
    logic [SLOTS-1:0]        pend_q;
    logic [SLOTS-1:0]        pend_d;

    always_comb begin
        scan_idx = '0;
        // Descending loop so the lowest pending slot wins.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                scan_idx = IDX_W'(i);
            end
        end
        scan_hit  = |pend_q;
        pend_d    = pend_q & ~(SLOTS'(1) << scan_idx);
        scan_last = (pend_d == '0);
    end
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

    logic [IDX_W-1:0]        slot_q;
    logic [IDX_W-1:0]        slot_d;

    always_comb begin
        scan_idx  = slot_q;
        scan_hit  = ~word_inv[slot_q];
        scan_last = (slot_q == LAST_IDX);
        slot_d    = slot_q + IDX_W'(1);
    end
`endif

    assign scan_move = word_mv[scan_idx];

    // Header / terminator addressing relative to the current count
    logic [ADDR_WIDTH-1:0]   list_addr;
    assign list_addr = LIST_A + {{(ADDR_WIDTH-8){1'b0}}, count_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            word_q       <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
`ifdef LMG_SEQ_SKIP_INVALID_EN
            pend_q       <= '0;
`else
            slot_q       <= '0;
`endif
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            move_count_q <= '0;
            overflow_q   <= 1'b0;
            lmg_reset_q  <= 1'b0;
            lmg_bstate_q <= '0;
            lmg_rden_q   <= 1'b0;
            ram_wraddr_q <= '0;
            ram_data_q   <= '0;
            ram_wren_q   <= 1'b0;
        end else begin
            start_prev_q <= start;
            // Pulse outputs default low; states that need them raise them.
            lmg_reset_q  <= 1'b0;
            lmg_rden_q   <= 1'b0;
            ram_wren_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start && !start_prev_q) begin
                        lmg_bstate_q <= board_in;
                        lmg_reset_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        count_q      <= '0;
                        ovf_q        <= 1'b0;
                        state_q      <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (lmg_done) begin
                        if (lmg_fifo_empty) begin
                            state_q <= S_HDR;
                        end else begin
                            lmg_rden_q <= 1'b1;
                            state_q    <= S_POP;
                        end
                    end
                end

                // lmg_rden is high during this cycle; FIFO data follows in LATCH.
                S_POP: begin
                    state_q <= S_LATCH;
                end

                S_LATCH: begin
                    word_q <= lmg_fifo_out;
`ifdef LMG_SEQ_SKIP_INVALID_EN
                    pend_q <= ~fifo_inv;
`else
                    slot_q <= '0;
`endif
                    // An all-invalid word marks the end of the move list.
                    if (&fifo_inv) begin
                        state_q <= S_HDR;
                    end else begin
                        state_q <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (scan_hit) begin
                        if (count_q < MAX_C) begin
                            ram_wraddr_q <= list_addr;
                            ram_data_q   <= {{(DATA_WIDTH-MOVE_W){1'b0}}, scan_move};
                            ram_wren_q   <= 1'b1;
                            count_q      <= count_q + 8'd1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
`ifdef LMG_SEQ_SKIP_INVALID_EN
                    pend_q <= pend_d;
`else
                    slot_q <= slot_d;
`endif
                    if (scan_last) begin
                        if (lmg_fifo_empty) begin
                            state_q <= S_HDR;
                        end else begin
                            lmg_rden_q <= 1'b1;
                            state_q    <= S_POP;
                        end
                    end
                end

                S_HDR: begin
                    ram_wraddr_q <= HDR_A;
                    ram_data_q   <= {{(DATA_WIDTH-8){1'b0}}, count_q};
                    ram_wren_q   <= 1'b1;
                    state_q      <= S_TERM;
                end

                // Terminator sits right after the last written move; at
                // saturation that is LIST_A + MAX_MOVES.
                S_TERM: begin
                    ram_wraddr_q <= list_addr;
                    ram_data_q   <= '0;
                    ram_wren_q   <= 1'b1;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    move_count_q <= count_q;
                    overflow_q   <= ovf_q;
                    state_q      <= S_DONE;
                end

                // Only a return of start to 0 leaves DONE, so a held start
                // can never relaunch a pass.
                S_DONE: begin
                    if (!start) begin
                        done_q       <= 1'b0;
                        move_count_q <= '0;
                        overflow_q   <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign move_count = move_count_q;
    assign overflow   = overflow_q;
    assign lmg_reset  = lmg_reset_q;
    assign lmg_bstate = lmg_bstate_q;
    assign lmg_rden   = lmg_rden_q;
    assign ram_wraddr = ram_wraddr_q;
    assign ram_data   = ram_data_q;
    assign ram_wren   = ram_wren_q;

endmodule
